// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters via valid/ready.
// Latency: request accepted in cycle T, ALU driven in T+1, registered response valid from T+2.
// Backpressure: no new request is accepted until the pending response is consumed.
// Optional: define ALU_ARB_RR_EN for round-robin arbitration (default: fixed, requester 0 wins).
module alu_arbiter #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req_a0,
  input  logic [N-1:0] req_b0,
  input  logic [N-1:0] req_a1,
  input  logic [N-1:0] req_b1,
  input  logic [3:0]   req_ctrl0,
  input  logic [3:0]   req_ctrl1,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [N-1:0] rsp_res,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [N-1:0] alu_res,
  input  logic [3:0]   alu_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] OP_MOD = 4'b0100;

  state_t       state_q;
  logic         grant_q;
  logic [1:0]   rsp_valid_q;
  logic [N-1:0] alu_a_q;
  logic [N-1:0] alu_b_q;
  logic [3:0]   alu_ctrl_q;
  logic [N-1:0] rsp_res_q;
  logic [3:0]   rsp_flags_q;
  logic         rsp_err_q;

  logic         win_d;
  logic         hs_d;
  logic         mod_zero_d;

`ifdef ALU_ARB_RR_EN
  logic         ptr_q;

  // Round-robin winner: the pointed-to requester wins if valid, otherwise the other one.
  always_comb begin
    win_d = ptr_q;
    if (!req_valid[ptr_q]) win_d = ~ptr_q;
  end
`else
  // Fixed priority winner: requester 0 whenever it is valid.
  always_comb begin
    win_d = ~req_valid[0];
  end
`endif

  assign hs_d       = (state_q == IDLE) && !rst && (|req_valid);
  assign mod_zero_d = (alu_ctrl_q == OP_MOD) && (alu_b_q == '0);

  // Ready goes only to the winner, and only while idle and out of reset.
  always_comb begin
    req_ready = 2'b00;
    if (hs_d) req_ready[win_d] = 1'b1;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctrl  = alu_ctrl_q;

  // Control FSM; ALU inputs are held in registers that are non-zero only during EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      rsp_valid_q <= 2'b00;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= 4'b0000;
      rsp_res_q   <= '0;
      rsp_flags_q <= 4'b0000;
      rsp_err_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (hs_d) begin
            grant_q    <= win_d;
            alu_a_q    <= win_d ? req_a1 : req_a0;
            alu_b_q    <= win_d ? req_b1 : req_b0;
            alu_ctrl_q <= win_d ? req_ctrl1 : req_ctrl0;
            state_q    <= EXEC;
`ifdef ALU_ARB_RR_EN
            ptr_q      <= ~win_d;
`endif
          end
        end
        EXEC: begin
          // A mod by zero bypasses the ALU and returns the dividend with the error bit.
          if (mod_zero_d) begin
            rsp_res_q   <= alu_a_q;
            rsp_flags_q <= 4'b0000;
            rsp_err_q   <= 1'b1;
          end else begin
            rsp_res_q   <= alu_res;
            rsp_flags_q <= alu_flags;
            rsp_err_q   <= 1'b0;
          end
          rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
          alu_a_q     <= '0;
          alu_b_q     <= '0;
          alu_ctrl_q  <= 4'b0000;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready[grant_q]) begin
            rsp_valid_q <= 2'b00;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed self-checking bench for alu_arbiter.
// Provides a behavioural ALU on the alu_* ports and a reference model for results and grants.
// Inputs driven on the falling edge, outputs sampled 1ns later.
module tb_alu_arbiter;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]   req_ctrl0, req_ctrl1;
  logic [N-1:0] rsp_res, alu_a, alu_b, alu_res;
  logic [3:0]   rsp_flags, alu_ctrl, alu_flags;
  logic         rsp_err;

  int checks = 0;
  int errors = 0;
  int ref_ptr = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_ctrl0(req_ctrl0), .req_ctrl1(req_ctrl1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_res(alu_res), .alu_flags(alu_flags)
  );

  // Behavioural ALU: returns {N,Z,C,V, result}. Mod by zero yields deliberate garbage.
  function automatic logic [N+3:0] alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [3:0] op);
    int sa, sb, s;
    longint ua, ub, u;
    logic [N-1:0] r;
    logic c, v;
    sa = int'($signed(a)); sb = int'($signed(b));
    ua = longint'(a); ub = longint'(b);
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin u = ua + ub; s = sa + sb; r = u[N-1:0]; c = (u > 65535); v = (s > 32767) || (s < -32768); end
      4'd1: begin u = ua - ub; s = sa - sb; r = u[N-1:0]; c = (ua >= ub); v = (s > 32767) || (s < -32768); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: begin
        if (b == '0) return {4'hF, 16'hDEAD};
        r = a % b;
      end
      default: r = a ^ b;
    endcase
    return {r[N-1], (r == '0), c, v, r};
  endfunction

  always_comb begin
    {alu_flags, alu_res} = alu_fn(alu_a, alu_b, alu_ctrl);
  end

  // Expected response {err, flags, res} for an accepted operation.
  function automatic logic [N+4:0] ref_op(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [3:0] op);
    if (op == 4'd4 && b == '0) return {1'b1, 4'b0000, a};
    return {1'b0, alu_fn(a, b, op)};
  endfunction

  // Expected grant for a valid mask.
  function automatic int ref_winner(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
`ifdef ALU_ARB_RR_EN
    return ref_ptr;
`else
    return 0;
`endif
  endfunction

  // Waits (bounded) for req_ready; called right after inputs are driven on a falling edge.
  task automatic wait_grant(output int gnt, output int cyc);
    gnt = -1; cyc = 0;
    #1;
    while (req_ready == 2'b00 && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    if (req_ready == 2'b01) gnt = 0;
    else if (req_ready == 2'b10) gnt = 1;
    else begin
      checks++; errors++;
      $display("FAIL grant_wait req_ready=%b after %0d cycles (need one-hot)", req_ready, cyc);
    end
  endtask

  // Runs one operation end to end; keep masks which req_valid bits stay high after accept.
  task automatic xact(input logic [1:0] keep, output int gnt, output int cyc,
                      output logic [N-1:0] oa, output logic [N-1:0] ob, output logic [3:0] oc,
                      output logic [1:0] rv_e, output logic [1:0] rv_r, output logic [N+4:0] orsp);
    oa = '0; ob = '0; oc = '0; rv_e = '0; rv_r = '0; orsp = '0;
    wait_grant(gnt, cyc);
    if (gnt >= 0) begin
      @(posedge clk);
      ref_ptr = 1 - gnt;
      @(negedge clk); req_valid = req_valid & keep; #1;
      oa = alu_a; ob = alu_b; oc = alu_ctrl; rv_e = rsp_valid;
      @(negedge clk); #1;
      rv_r = rsp_valid; orsp = {rsp_err, rsp_flags, rsp_res};
      rsp_ready = 2'b11;
      @(posedge clk);
      @(negedge clk); rsp_ready = 2'b00;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
    req_a0 = 16'h1111; req_b0 = 16'h2222; req_a1 = 16'h3333; req_b1 = 16'h4444;
    req_ctrl0 = 4'd0; req_ctrl1 = 4'd0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_res, rsp_flags, rsp_err} !== '0) begin
      errors++; $display("FAIL reset_rsp got=%h need 0", {rsp_valid, rsp_res, rsp_flags, rsp_err});
    end
    checks++;
    if ({alu_a, alu_b, alu_ctrl} !== '0) begin
      errors++; $display("FAIL reset_alu got=%h need 0", {alu_a, alu_b, alu_ctrl});
    end
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b need 00", req_ready); end
    req_valid = 2'b00;
    @(negedge clk); rst = 1'b0;
    ref_ptr = 0;
  endtask

  task automatic test_single_add();
    int g, c; logic [N-1:0] oa, ob; logic [3:0] oc; logic [1:0] ve, vr; logic [N+4:0] r;
    req_a0 = 16'h0003; req_b0 = 16'h0004; req_ctrl0 = 4'b0000; req_valid = 2'b01;
    xact(2'b00, g, c, oa, ob, oc, ve, vr, r);
    req_valid = 2'b00;
    checks++; if (g !== 0) begin errors++; $display("FAIL add_grant got=%0d need 0", g); end
    checks++; if (c !== 0) begin errors++; $display("FAIL add_ready_delay got=%0d need 0", c); end
    checks++;
    if ({oa, ob, oc} !== {16'h0003, 16'h0004, 4'b0000}) begin
      errors++; $display("FAIL add_alu_in got=%h/%h/%h need 0003/0004/0", oa, ob, oc);
    end
    checks++; if (ve !== 2'b00) begin errors++; $display("FAIL add_early_valid got=%b need 00", ve); end
    checks++; if (vr !== 2'b01) begin errors++; $display("FAIL add_rsp_valid got=%b need 01", vr); end
    checks++;
    if (r !== {1'b0, 4'b0000, 16'h0007}) begin
      errors++; $display("FAIL add_rsp got=%h need %h", r, {1'b0, 4'b0000, 16'h0007});
    end
  endtask

  task automatic test_overflow_sub();
    int g, c; logic [N-1:0] oa, ob; logic [3:0] oc; logic [1:0] ve, vr; logic [N+4:0] r;
    req_a1 = 16'h8000; req_b1 = 16'h0001; req_ctrl1 = 4'b0001; req_valid = 2'b10;
    xact(2'b00, g, c, oa, ob, oc, ve, vr, r);
    req_valid = 2'b00;
    checks++; if (vr !== 2'b10) begin errors++; $display("FAIL sub_rsp_valid got=%b need 10", vr); end
    checks++; if (oc !== 4'b0001) begin errors++; $display("FAIL sub_alu_ctrl got=%h need 1", oc); end
    checks++;
    if (r !== {1'b0, 4'b0011, 16'h7FFF}) begin
      errors++; $display("FAIL sub_rsp got=%h need %h", r, {1'b0, 4'b0011, 16'h7FFF});
    end
  endtask

  task automatic test_contention();
    int g, c, exp_g; logic [N-1:0] oa, ob; logic [3:0] oc; logic [1:0] ve, vr; logic [N+4:0] r, er;
    req_a0 = 16'($urandom); req_b0 = 16'($urandom); req_a1 = 16'($urandom); req_b1 = 16'($urandom);
    req_ctrl0 = 4'b0010; req_ctrl1 = 4'b0010; req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      exp_g = ref_winner(2'b11);
      xact(2'b11, g, c, oa, ob, oc, ve, vr, r);
      er = (exp_g == 1) ? ref_op(req_a1, req_b1, 4'b0010) : ref_op(req_a0, req_b0, 4'b0010);
      checks++;
      if (g !== exp_g) begin errors++; $display("FAIL contend_grant[%0d] got=%0d need %0d", i, g, exp_g); end
      checks++;
      if (c !== 0) begin errors++; $display("FAIL contend_rate[%0d] waited=%0d need 0", i, c); end
      checks++;
      if (r !== er) begin errors++; $display("FAIL contend_rsp[%0d] got=%h need %h", i, r, er); end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_mod_zero();
    int g, c; logic [N-1:0] oa, ob; logic [3:0] oc; logic [1:0] ve, vr; logic [N+4:0] r;
    req_a0 = 16'h0055; req_b0 = 16'h0000; req_ctrl0 = 4'b0100; req_valid = 2'b01;
    xact(2'b00, g, c, oa, ob, oc, ve, vr, r);
    req_valid = 2'b00;
    checks++; if (vr !== 2'b01) begin errors++; $display("FAIL modz_valid got=%b need 01", vr); end
    checks++;
    if ($isunknown(r) || r !== {1'b1, 4'b0000, 16'h0055}) begin
      errors++; $display("FAIL modz_rsp got=%h need %h", r, {1'b1, 4'b0000, 16'h0055});
    end
  endtask

  task automatic test_backpressure();
    int g, c; logic [N-1:0] oa, ob; logic [3:0] oc; logic [1:0] ve, vr; logic [N+4:0] r, er0, er1;
    req_a0 = 16'($urandom); req_b0 = 16'($urandom); req_ctrl0 = 4'b0000; req_valid = 2'b01;
    req_a1 = 16'($urandom); req_b1 = 16'($urandom); req_ctrl1 = 4'b0001;
    er0 = ref_op(req_a0, req_b0, 4'b0000);
    er1 = ref_op(req_a1, req_b1, 4'b0001);
    wait_grant(g, c);
    if (g >= 0) begin
      @(posedge clk); ref_ptr = 1 - g;
      @(negedge clk); req_valid = 2'b10;
      @(negedge clk); rsp_ready = 2'b10;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_err, rsp_flags, rsp_res} !== {2'b01, er0}) begin
          errors++; $display("FAIL bp_hold[%0d] got=%h need %h", i, {rsp_valid, rsp_err, rsp_flags, rsp_res}, {2'b01, er0});
        end
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d] got=%b need 00", i, req_ready); end
      end
      rsp_ready = 2'b01;
      @(posedge clk);
      @(negedge clk); rsp_ready = 2'b00; #1;
      checks++;
      if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_next_ready got=%b need 10", req_ready); end
      xact(2'b00, g, c, oa, ob, oc, ve, vr, r);
      checks++;
      if ({vr, r} !== {2'b10, er1}) begin errors++; $display("FAIL bp_req1_rsp got=%h need %h", {vr, r}, {2'b10, er1}); end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid();
    int g, c; logic [N-1:0] oa, ob; logic [3:0] oc; logic [1:0] ve, vr; logic [N+4:0] r, er;
    req_a0 = 16'h1234; req_b0 = 16'h0FF0; req_ctrl0 = 4'b0011; req_valid = 2'b01;
    wait_grant(g, c);
    if (g >= 0) begin
      @(posedge clk); ref_ptr = 1 - g;
      @(negedge clk); req_valid = 2'b00;
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rstmid_pre got=%b need 01", rsp_valid); end
      rst = 1'b1; #1;
      checks++;
      if ({rsp_valid, rsp_res, rsp_flags, rsp_err, alu_a, alu_b, alu_ctrl} !== '0) begin
        errors++; $display("FAIL rstmid_clear got=%h need 0", {rsp_valid, rsp_res, rsp_flags, rsp_err, alu_a, alu_b, alu_ctrl});
      end
      @(negedge clk); rst = 1'b0; ref_ptr = 0;
    end
    req_a0 = 16'h00F7; req_b0 = 16'h0009; req_ctrl0 = 4'b0100;
    req_a1 = 16'h5555; req_b1 = 16'h0001; req_ctrl1 = 4'b0000; req_valid = 2'b11;
    er = ref_op(16'h00F7, 16'h0009, 4'b0100);
    xact(2'b00, g, c, oa, ob, oc, ve, vr, r);
    req_valid = 2'b00;
    checks++; if (g !== 0) begin errors++; $display("FAIL rstmid_grant got=%0d need 0", g); end
    checks++;
    if ({c[1:0], ve, vr} !== {2'b00, 2'b00, 2'b01}) begin
      errors++; $display("FAIL rstmid_latency wait=%0d exec_v=%b resp_v=%b need 0/00/01", c, ve, vr);
    end
    checks++; if (r !== er) begin errors++; $display("FAIL rstmid_rsp got=%h need %h", r, er); end
  endtask

  task automatic test_random();
    int g, c, exp_g; logic [N-1:0] oa, ob, ea, eb; logic [3:0] oc, ec;
    logic [1:0] ve, vr, vm; logic [N+4:0] r, er;
    for (int i = 0; i < 40; i++) begin
      vm = 2'($urandom_range(1, 3));
      req_a0 = 16'($urandom); req_a1 = 16'($urandom);
      req_b0 = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      req_b1 = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      req_ctrl0 = 4'($urandom_range(0, 5)); req_ctrl1 = 4'($urandom_range(0, 5));
      exp_g = ref_winner(vm);
      ea = exp_g ? req_a1 : req_a0; eb = exp_g ? req_b1 : req_b0; ec = exp_g ? req_ctrl1 : req_ctrl0;
      er = ref_op(ea, eb, ec);
      req_valid = vm;
      xact(2'b00, g, c, oa, ob, oc, ve, vr, r);
      req_valid = 2'b00;
      checks++;
      if (g !== exp_g) begin errors++; $display("FAIL rnd_grant[%0d] mask=%b got=%0d need %0d", i, vm, g, exp_g); end
      checks++;
      if ({oa, ob, oc} !== {ea, eb, ec}) begin
        errors++; $display("FAIL rnd_alu_in[%0d] got=%h need %h", i, {oa, ob, oc}, {ea, eb, ec});
      end
      checks++;
      if (vr !== ((exp_g == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rnd_valid[%0d] got=%b", i, vr); end
      checks++;
      if (r !== er) begin errors++; $display("FAIL rnd_rsp[%0d] got=%h need %h", i, r, er); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_add();
    test_overflow_sub();
    test_contention();
    test_mod_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
